// File: rtl/noc_sim_sequencer.sv
// rtl/noc_sim_sequencer.sv - top-level phase sequencer for the NoC cycle simulator
//
// Walks traffic init, traffic fill, pre-dequeue, router init and routing-table
// load, then loops staging / phase 0 / phase 1 / end check once per simulated
// cycle. Supports a cycle limit (timeout), single-step pausing and restart
// from DONE without reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             pulse, begins a run from IDLE or DONE (max_cycle latched)
//   max_cycle         cycle limit, 0 = unlimited
//   step_mode, step   pause after each end check / release one cycle
//   tf_count          per-source packet counts, slice i = source i
//   rt_valid          per-router routing entry valid for rt_dst
//   inject_ok         per-source head flit injectable
//   router_done       per-router drained flag
//   router_op/_en     broadcast router op and per-router enable
//   traffic_op/_en    broadcast traffic op and per-source enable
//   fill_idx, rt_dst  packet index in FILL, destination index in LOAD_RT
//   in_cycle          completed simulated cycles (saturating)
//   busy, finished, timeout  run status
module noc_sim_sequencer #(
  parameter int NUM_ROUTERS = 16,
  parameter int RID_W       = 4,
  parameter int CYCLE_W     = 32,
  parameter int CNT_W       = 10,
  parameter int OP_W        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CYCLE_W-1:0]           max_cycle,
  input  logic                         step_mode,
  input  logic                         step,
  input  logic [NUM_ROUTERS*CNT_W-1:0] tf_count,
  input  logic [NUM_ROUTERS-1:0]       rt_valid,
  input  logic [NUM_ROUTERS-1:0]       inject_ok,
  input  logic [NUM_ROUTERS-1:0]       router_done,
  output logic [OP_W-1:0]              router_op,
  output logic [NUM_ROUTERS-1:0]       router_en,
  output logic [OP_W-1:0]              traffic_op,
  output logic [NUM_ROUTERS-1:0]       traffic_en,
  output logic [CNT_W-1:0]             fill_idx,
  output logic [RID_W-1:0]             rt_dst,
  output logic [CYCLE_W-1:0]           in_cycle,
  output logic                         busy,
  output logic                         finished,
  output logic                         timeout
);

  localparam logic [OP_W-1:0] OP_NOP      = OP_W'(0);
  localparam logic [OP_W-1:0] OP_PHASE0   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_PHASE1   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_STAGING  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LOAD_RT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_INIT     = OP_W'(5);
  localparam logic [OP_W-1:0] OP_FILL     = OP_W'(6);
  localparam logic [OP_W-1:0] OP_DEQUEUE  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_PRE_DEQ  = OP_W'(8);

  localparam logic [RID_W-1:0]   LAST_RID  = RID_W'(NUM_ROUTERS - 1);
  localparam logic [CYCLE_W-1:0] CYCLE_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_TRAFFIC,
    S_FILL,
    S_PRE_DEQ,
    S_INIT_ROUTER,
    S_LOAD_RT,
    S_LOAD_STAGING,
    S_PHASE0,
    S_PHASE1,
    S_CHECK_END,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t               state;
  logic [CYCLE_W-1:0]   max_cycle_q;
  logic [NUM_ROUTERS-1:0] fill_en;

  // Sources that still have a packet at the current fill index.
  always_comb begin
    fill_en = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      fill_en[i] = (tf_count[i*CNT_W +: CNT_W] > fill_idx);
    end
  end

  // Op decode is a pure function of the state register, except for the three
  // per-node enable masks that pass straight through from their inputs.
  always_comb begin
    router_op  = OP_NOP;
    router_en  = '0;
    traffic_op = OP_NOP;
    traffic_en = '0;
    case (state)
      S_INIT_TRAFFIC: begin traffic_op = OP_INIT;    traffic_en = '1;        end
      S_FILL:         begin traffic_op = OP_FILL;    traffic_en = fill_en;   end
      S_PRE_DEQ:      begin traffic_op = OP_PRE_DEQ; traffic_en = '1;        end
      S_INIT_ROUTER:  begin router_op  = OP_INIT;    router_en  = '1;        end
      S_LOAD_RT:      begin router_op  = OP_LOAD_RT; router_en  = rt_valid;  end
      S_LOAD_STAGING: begin
        router_op  = OP_STAGING;
        router_en  = '1;
        traffic_op = OP_DEQUEUE;
        traffic_en = inject_ok;
      end
      S_PHASE0:       begin router_op  = OP_PHASE0;  router_en  = '1;        end
      S_PHASE1:       begin router_op  = OP_PHASE1;  router_en  = '1;        end
      default:        ;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      max_cycle_q <= '0;
      fill_idx    <= '0;
      rt_dst      <= '0;
      in_cycle    <= '0;
      finished    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_INIT_TRAFFIC;
            max_cycle_q <= max_cycle;
            fill_idx    <= '0;
            rt_dst      <= '0;
            in_cycle    <= '0;
            finished    <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        S_INIT_TRAFFIC: state <= S_FILL;
        S_FILL: begin
          // The final FILL cycle is the one where no source has a packet left.
          if (|fill_en) fill_idx <= fill_idx + CNT_W'(1);
          else          state    <= S_PRE_DEQ;
        end
        S_PRE_DEQ:     state <= S_INIT_ROUTER;
        S_INIT_ROUTER: state <= S_LOAD_RT;
        S_LOAD_RT: begin
          if (rt_dst == LAST_RID) state  <= S_LOAD_STAGING;
          else                    rt_dst <= rt_dst + RID_W'(1);
        end
        S_LOAD_STAGING: state <= S_PHASE0;
        S_PHASE0:       state <= S_PHASE1;
        S_PHASE1: begin
          state <= S_CHECK_END;
          if (in_cycle != CYCLE_MAX) in_cycle <= in_cycle + CYCLE_W'(1);
        end
        S_CHECK_END: begin
          if (&router_done) begin
            state    <= S_DONE;
            finished <= 1'b1;
          end else if ((max_cycle_q != '0) && (in_cycle == max_cycle_q)) begin
            state   <= S_DONE;
            timeout <= 1'b1;
          end else if (step_mode) begin
            state <= S_PAUSE;
          end else begin
            state <= S_LOAD_STAGING;
          end
        end
        S_PAUSE: begin
          if (step || !step_mode) state <= S_LOAD_STAGING;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc_sim_sequencer.md
# noc_sim_sequencer

Parametrised top-level sequencer for the NoC cycle simulator. It replaces the testbench-only state loop with a synthesisable FSM that broadcasts operation codes to NUM_ROUTERS routers and NUM_ROUTERS traffic sources, with per-node enables. It walks the phases traffic init, traffic fill, pre-dequeue, router init, routing-table load, then the per-cycle loop of staging, phase 0, phase 1 and end check. It adds three things: a cycle limit with timeout, single-step mode, and restart without reset.

## Interface
Parameters:
- NUM_ROUTERS, 16, number of routers/traffic sources
- RID_W, 4, router index width (2^RID_W >= NUM_ROUTERS)
- CYCLE_W, 32, simulated-cycle counter width
- CNT_W, 10, per-source packet count / fill index width
- OP_W, 4, op code width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- max_cycle  in  CYCLE_W  cycle limit; 0 = unlimited; sampled on start
- step_mode  in  1  1 = pause after every CHECK_END
- step  in  1  pulse; releases one simulated cycle in PAUSE
- tf_count  in  NUM_ROUTERS*CNT_W  packets queued per source; slice i belongs to source i
- rt_valid  in  NUM_ROUTERS  bit i = router i has a routing entry for rt_dst
- inject_ok  in  NUM_ROUTERS  bit i = source i head flit may be injected
- router_done  in  NUM_ROUTERS  per-router drained flag
- router_op  out  OP_W  broadcast router op
- router_en  out  NUM_ROUTERS  per-router op enable
- traffic_op  out  OP_W  broadcast traffic op
- traffic_en  out  NUM_ROUTERS  per-source op enable
- fill_idx  out  CNT_W  packet index during FILL
- rt_dst  out  RID_W  destination index during LOAD_RT
- in_cycle  out  CYCLE_W  completed simulated cycles
- busy  out  1  1 in every state except IDLE/DONE
- finished  out  1  run ended with all routers done
- timeout  out  1  run ended on max_cycle

## Operation
- Op encodings: NOP=0, Phase0=1, Phase1=2, LoadStaging=3, LoadRt=4, Init=5, Fill=6, Dequeue=7, PreDeque=8.
- States and the ops they drive:
  - IDLE: no ops.
  - INIT_TRAFFIC: traffic_op=Init, all traffic_en.
  - FILL: traffic_op=Fill, traffic_en[i] = (tf_count[i] > fill_idx).
  - PRE_DEQ: traffic_op=PreDeque, all traffic_en.
  - INIT_ROUTER: router_op=Init, all router_en.
  - LOAD_RT: router_op=LoadRt, router_en=rt_valid.
  - LOAD_STAGING: router_op=LoadStaging, all router_en; traffic_op=Dequeue, traffic_en=inject_ok.
  - PHASE0: router_op=Phase0, all router_en.
  - PHASE1: router_op=Phase1, all router_en.
  - CHECK_END: no ops.
  - PAUSE: no ops.
  - DONE: no ops.
- Any state not listed as driving an op drives op=NOP and enables 0.
- Transitions:
  - IDLE/DONE -> INIT_TRAFFIC on start. Start clears in_cycle, fill_idx, rt_dst, finished and timeout, and latches max_cycle.
  - INIT_TRAFFIC -> FILL.
  - FILL: if any tf_count[i] > fill_idx, stay and increment fill_idx. Otherwise the enables are all 0 and the FSM goes to PRE_DEQ. FILL lasts max(tf_count)+1 cycles.
  - PRE_DEQ -> INIT_ROUTER -> LOAD_RT.
  - LOAD_RT steps rt_dst from 0 to NUM_ROUTERS-1, one per cycle (exactly NUM_ROUTERS cycles), then goes to LOAD_STAGING.
  - LOAD_STAGING -> PHASE0 -> PHASE1 -> CHECK_END. in_cycle increments on leaving PHASE1.
  - CHECK_END priority:
    1. All router_done -> DONE, finished=1.
    2. Else latched max_cycle != 0 and in_cycle == max_cycle -> DONE, timeout=1.
    3. Else step_mode -> PAUSE.
    4. Else -> LOAD_STAGING.
  - PAUSE -> LOAD_STAGING on step. step_mode deasserted in PAUSE also releases.
- start while busy is ignored. step outside PAUSE is ignored.
- in_cycle saturates at all-ones and does not wrap.

## Timing
- The state register is the only sequencing element. Ops, enables, fill_idx and rt_dst are valid for the whole cycle the FSM occupies the state.
- The only combinational input-to-output paths are: rt_valid to router_en, inject_ok to traffic_en, and tf_count to traffic_en.
- start sampled at edge t -> INIT_TRAFFIC in cycle t+1.
- One simulated cycle costs 4 clocks (LOAD_STAGING..CHECK_END), plus PAUSE time.
- Reset, including mid-run: state=IDLE. Ops are NOP, all enables 0, and in_cycle, fill_idx, rt_dst, busy, finished and timeout are all 0.
- rst has priority over start and step in the same cycle.

## Test plan
- NUM_ROUTERS=4, tf_count={3,0,1,0}, start -> FILL lasts 4 cycles. traffic_en per FILL cycle is 0101, 0001, 0001, 0000, with fill_idx 0, 1, 2, 3.
- rt_valid=0110 held through LOAD_RT -> 4 LoadRt cycles, rt_dst 0..3, router_en=0110 each cycle.
- router_done all 1 from start -> first CHECK_END goes to DONE with in_cycle=1, finished=1, timeout=0, busy=0.
- max_cycle=5, router_done=0 -> timeout=1 and in_cycle=5 after 5 loop iterations; no LOAD_STAGING follows.
- step_mode=1 -> FSM holds PAUSE for 10 clocks with all ops NOP; a step pulse gives exactly one more loop and in_cycle+1.
- rst asserted during PHASE0 -> next cycle IDLE with all outputs 0; a following start reruns from INIT_TRAFFIC with in_cycle=0.
